huffman_bitpacker: RTL and testbench
====================================

Name: huffman_bitpacker

Overview:
- Downstream consumer of the huffman stage's code table (code_valid, HC1..HC6, M1..M6).
- Re-streams the same 8-bit gray-level symbols (values 1..6) and replaces each one with its Huffman codeword.
- Packs the codewords MSB-first into bytes and presents them on a valid/ready byte stream for capture by ILA or a later UART/memory writer.

Parameters:
- ACC_W, 16, bit-accumulator width; fixed at 16, with the count register 5 bits wide (0..16).
- TB_W, 16, width of the total_bits counter; saturates at all-ones.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- code_valid  in  1  one-cycle pulse; HC1..HC6 and M1..M6 are valid in this cycle.
- HC1..HC6  in  8 each  codeword for symbol n, right-aligned.
- M1..M6  in  8 each  mask for symbol n: contiguous ones in the low L bits, where L = codeword length (1..8).
- sym_valid  in  1  symbol present.
- sym_data  in  8  gray-level symbol.
- sym_last  in  1  marks the final symbol of the frame.
- sym_ready  out  1  symbol accepted when sym_valid && sym_ready.
- out_valid  out  1  byte present.
- out_byte  out  8  packed byte; first codeword bit is in bit 7.
- out_last  out  1  asserted with the final byte of the frame.
- out_ready  in  1  byte consumed when out_valid && out_ready.
- done  out  1  frame fully emitted.
- err_sym  out  1  sticky; an invalid symbol was dropped.
- total_bits  out  TB_W  codeword bits packed in the current frame.

Behaviour:
- Reset values: sym_ready, out_valid, out_last, done, err_sym = 0; out_byte = 0; total_bits = 0; accumulator and count = 0; table registers = 0; state = WAIT_TBL.
- State WAIT_TBL:
  - sym_ready = 0.
  - On code_valid: latch HC/M into internal table registers, clear total_bits and err_sym, go to ENCODE.
- State ENCODE:
  - sym_ready = (cnt <= 8). This is combinational from registered state.
  - Codeword length L = popcount(Mn).
  - On accept: append HC[L-1:0] below the cnt valid bits, MSB-first; cnt += L; total_bits += L (saturating).
  - If sym_last is accepted: go to FLUSH.
- Invalid symbol (sym_data = 0, sym_data > 6, or Mn = 0):
  - Still handshaken and consumed; no bits are appended; err_sym is set.
  - If it carries sym_last, still go to FLUSH.
- Byte output register:
  - Loaded with acc[15:8] when cnt >= 8 and the register is empty or being drained (!out_valid || out_ready).
  - On load: accumulator shifts left 8; cnt -= 8.
  - out_byte and out_last are held stable while out_valid && !out_ready.
- Simultaneous accept and byte load in one cycle:
  - cnt_next = cnt + L - 8.
  - The load uses the pre-accept accumulator bits.
- Latency:
  - A symbol accepted in cycle N contributes to a byte no earlier than out_valid at N+1.
  - Throughput is up to one byte per cycle.
- State FLUSH:
  - sym_ready = 0.
  - Drain all full bytes.
  - When 0 < cnt < 8 and the output register is free: emit the remaining bits left-aligned, zero-padded, with out_last = 1, and set cnt = 0.
  - If cnt reaches exactly 0 via a full-byte load, that byte carries out_last = 1.
  - If cnt = 0 on entry (nothing pending): no byte is emitted.
  - Go to DONE once the out_last byte has been handshaken, or immediately if there was nothing pending.
- State DONE:
  - done = 1; total_bits and err_sym are held.
  - On code_valid: relatch the table, clear counters, done = 0, go to ENCODE.
- code_valid in ENCODE or FLUSH: ignored; the table is stable for the whole frame.
- Reset mid-frame:
  - All state is cleared immediately (asynchronous).
  - Any pending bits and the held byte are discarded.
  - After release, the block waits in WAIT_TBL.

Test Plan:
- Packing:
  - Table: sym1 = HC 00 / M 01, sym2 = 02/03, sym3 = 06/07, sym4 = 0E/0F, sym5 = 1E/1F, sym6 = 1F/1F.
  - Stimulus: stream 1, 2, 3, 4 (last on 4), out_ready = 1.
  - Required: bytes 0x5B then 0x80 with out_last = 1; total_bits = 10; done = 1.
- Byte-aligned end:
  - Stimulus: same table, eight symbols of 6, last on the eighth.
  - Required: exactly five 0xFF bytes, out_last on the fifth; total_bits = 40; no padding byte.
- Backpressure:
  - Stimulus: a long stream of 6, out_ready = 0 for 10 cycles.
  - Required: out_byte stays 0xFF and stable; sym_ready drops once cnt > 8; no symbol lost or duplicated; byte count matches after out_ready returns to 1.
- Invalid symbol:
  - Stimulus: stream 1, 0, 9, 2 (last on 2).
  - Required: err_sym = 1; output 0x40 with out_last; total_bits = 3.
- Empty frame:
  - Stimulus: single symbol 0 with sym_last.
  - Required: no byte emitted; done = 1; total_bits = 0; err_sym = 1.
- Reset and restart:
  - Stimulus: assert rst_n mid-FLUSH with out_valid high.
  - Required: outputs go to 0 asynchronously; state is WAIT_TBL.
  - Then a new code_valid plus the packing stream reproduces 0x5B, 0x80.

Source files
------------

// File: rtl/huffman_bitpacker_if.sv
`default_nettype none
// ============================================================================
// Module   : huffman_bitpacker_if
// Purpose  : Symbol input stream and packed-byte output stream of the packer.
// Revision : 1.0 - initial release
// ============================================================================
interface huffman_bitpacker_if;
  logic       sym_valid;
  logic [7:0] sym_data;
  logic       sym_last;
  logic       sym_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_last;
  logic       out_ready;

  // slave: the packer itself; master: symbol source plus byte sink
  modport slave (
    input  sym_valid, sym_data, sym_last, out_ready,
    output sym_ready, out_valid, out_byte, out_last
  );

  modport master (
    output sym_valid, sym_data, sym_last, out_ready,
    input  sym_ready, out_valid, out_byte, out_last
  );
endinterface
`default_nettype wire

// File: rtl/huffman_bitpacker.sv
`default_nettype none
// ============================================================================
// Module   : huffman_bitpacker
// Purpose  : Replaces gray-level symbols with Huffman codewords, packs MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module huffman_bitpacker #(
  parameter int ACC_W = 16,
  parameter int TB_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               code_valid,
  input  logic [7:0]         HC1,
  input  logic [7:0]         HC2,
  input  logic [7:0]         HC3,
  input  logic [7:0]         HC4,
  input  logic [7:0]         HC5,
  input  logic [7:0]         HC6,
  input  logic [7:0]         M1,
  input  logic [7:0]         M2,
  input  logic [7:0]         M3,
  input  logic [7:0]         M4,
  input  logic [7:0]         M5,
  input  logic [7:0]         M6,
  huffman_bitpacker_if.slave stream,
  output logic               done,
  output logic               err_sym,
  output logic [TB_W-1:0]    total_bits
);

  localparam int c_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_WAIT_TBL = 2'd0,
    ST_ENCODE   = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [7:0]           r_hc [0:5];
  logic [7:0]           r_m  [0:5];
  logic [ACC_W-1:0]     r_acc;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_out_valid;
  logic [7:0]           r_out_byte;
  logic                 r_out_last;
  logic                 r_done;
  logic                 r_err;
  logic [TB_W-1:0]      r_total;

  logic [ACC_W-1:0]     w_acc_next;
  logic [c_CNT_W-1:0]   w_cnt_next;
  logic                 w_out_valid_next;
  logic [7:0]           w_out_byte_next;
  logic                 w_out_last_next;
  logic                 w_done_next;
  logic                 w_err_next;
  logic [TB_W-1:0]      w_total_next;
  logic                 w_load_tbl;

  logic [2:0]           w_idx;
  logic                 w_in_range;
  logic [7:0]           w_code;
  logic [7:0]           w_mask;
  logic [3:0]           w_len;
  logic                 w_sym_ok;
  logic [7:0]           w_bits;
  logic [c_CNT_W-1:0]   w_shamt;
  logic [ACC_W-1:0]     w_ins;
  logic                 w_sym_ready;
  logic                 w_accept;
  logic                 w_take_bits;
  logic                 w_can_load;
  logic                 w_full_load;
  logic                 w_part_load;
  logic                 w_final;
  logic [ACC_W-1:0]     w_acc_sum;
  logic [c_CNT_W-1:0]   w_cnt_sum;
  logic [c_CNT_W-1:0]   w_cnt_after_load;
  logic [TB_W:0]        w_tot_sum;

  // Symbol decode and codeword alignment into the accumulator
  always_comb begin
    w_idx      = 3'(sym_data_low() - 3'd1);
    w_in_range = (stream.sym_data >= 8'd1) && (stream.sym_data <= 8'd6);
    w_code     = 8'h00;
    w_mask     = 8'h00;
    if (w_in_range) begin
      w_code = r_hc[w_idx];
      w_mask = r_m[w_idx];
    end
    w_len = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_len = w_len + {3'b000, w_mask[i]};
    end
    w_sym_ok = w_in_range && (w_len != 4'd0);
    w_bits   = w_code & w_mask;
    // New bits land directly below the r_cnt valid bits held at the MSB end
    w_shamt  = 5'd16 - r_cnt - {1'b0, w_len};
    w_ins    = {{(ACC_W-8){1'b0}}, w_bits} << w_shamt;
  end

  function automatic logic [2:0] sym_data_low();
    return stream.sym_data[2:0];
  endfunction

  assign w_sym_ready = (r_state == ST_ENCODE) && (r_cnt <= 5'd8);
  assign w_accept    = w_sym_ready && stream.sym_valid;
  assign w_take_bits = w_accept && w_sym_ok;
  assign w_can_load  = !r_out_valid || stream.out_ready;
  assign w_full_load = ((r_state == ST_ENCODE) || (r_state == ST_FLUSH)) &&
                       (r_cnt >= 5'd8) && w_can_load;
  assign w_part_load = (r_state == ST_FLUSH) && (r_cnt != 5'd0) &&
                       (r_cnt < 5'd8) && w_can_load;
  assign w_final     = (r_state == ST_FLUSH) || (w_accept && stream.sym_last);

  assign w_acc_sum        = r_acc | (w_take_bits ? w_ins : '0);
  assign w_cnt_sum        = r_cnt + (w_take_bits ? {1'b0, w_len} : 5'd0);
  assign w_cnt_after_load = w_cnt_sum - 5'd8;
  assign w_tot_sum        = {1'b0, r_total} + {{(TB_W-3){1'b0}}, w_len};

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_cnt_next       = r_cnt;
    w_out_valid_next = r_out_valid;
    w_out_byte_next  = r_out_byte;
    w_out_last_next  = r_out_last;
    w_done_next      = r_done;
    w_err_next       = r_err;
    w_total_next     = r_total;
    w_load_tbl       = 1'b0;

    // Byte register: a load uses the accumulator as it stood before this cycle's symbol
    if (w_full_load) begin
      w_out_valid_next = 1'b1;
      w_out_byte_next  = r_acc[ACC_W-1 -: 8];
      w_out_last_next  = w_final && (w_cnt_after_load == 5'd0);
      w_acc_next       = w_acc_sum << 8;
      w_cnt_next       = w_cnt_after_load;
    end else if (w_part_load) begin
      w_out_valid_next = 1'b1;
      w_out_byte_next  = r_acc[ACC_W-1 -: 8];
      w_out_last_next  = 1'b1;
      w_acc_next       = '0;
      w_cnt_next       = 5'd0;
    end else begin
      if (r_out_valid && stream.out_ready) begin
        w_out_valid_next = 1'b0;
        w_out_last_next  = 1'b0;
      end
      w_acc_next = w_acc_sum;
      w_cnt_next = w_cnt_sum;
    end

    if (w_take_bits) begin
      w_total_next = w_tot_sum[TB_W] ? {TB_W{1'b1}} : w_tot_sum[TB_W-1:0];
    end
    if (w_accept && !w_sym_ok) begin
      w_err_next = 1'b1;
    end

    case (r_state)
      ST_WAIT_TBL, ST_DONE: begin
        if (code_valid) begin
          w_load_tbl   = 1'b1;
          w_total_next = '0;
          w_err_next   = 1'b0;
          w_done_next  = 1'b0;
          w_acc_next   = '0;
          w_cnt_next   = 5'd0;
          w_state_next = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        if (w_accept && stream.sym_last) begin
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if ((r_out_valid && r_out_last && stream.out_ready) ||
            ((r_cnt == 5'd0) && !r_out_valid)) begin
          w_done_next  = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_WAIT_TBL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_TBL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= 5'd0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_total     <= '0;
    end else begin
      r_acc       <= w_acc_next;
      r_cnt       <= w_cnt_next;
      r_out_valid <= w_out_valid_next;
      r_out_byte  <= w_out_byte_next;
      r_out_last  <= w_out_last_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
      r_total     <= w_total_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        r_hc[i] <= 8'h00;
        r_m[i]  <= 8'h00;
      end
    end else if (w_load_tbl) begin
      r_hc[0] <= HC1;
      r_hc[1] <= HC2;
      r_hc[2] <= HC3;
      r_hc[3] <= HC4;
      r_hc[4] <= HC5;
      r_hc[5] <= HC6;
      r_m[0]  <= M1;
      r_m[1]  <= M2;
      r_m[2]  <= M3;
      r_m[3]  <= M4;
      r_m[4]  <= M5;
      r_m[5]  <= M6;
    end
  end

  assign stream.sym_ready = w_sym_ready;
  assign stream.out_valid = r_out_valid;
  assign stream.out_byte  = r_out_byte;
  assign stream.out_last  = r_out_last;
  assign done             = r_done;
  assign err_sym          = r_err;
  assign total_bits       = r_total;

endmodule
`default_nettype wire

// File: tb/tb_huffman_bitpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_huffman_bitpacker
// Purpose  : Scoreboard bench for huffman_bitpacker packing, flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_huffman_bitpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        code_valid;
  logic [7:0]  hc_p [1:6];
  logic [7:0]  m_p  [1:6];
  logic        done;
  logic        err_sym;
  logic [15:0] total_bits;

  logic [7:0]  tbl_hc [1:6];
  logic [7:0]  tbl_m  [1:6];
  logic [8:0]  exp_q [$];
  logic [7:0]  stim_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          frame_bytes;
  int          exp_total;
  int          exp_err;
  int          exp_nbytes;

  always #5 clk = ~clk;

  huffman_bitpacker_if bus_if ();

  huffman_bitpacker #(.ACC_W(16), .TB_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .HC1 (hc_p[1]), .HC2 (hc_p[2]), .HC3 (hc_p[3]),
    .HC4 (hc_p[4]), .HC5 (hc_p[5]), .HC6 (hc_p[6]),
    .M1  (m_p[1]),  .M2  (m_p[2]),  .M3  (m_p[3]),
    .M4  (m_p[4]),  .M5  (m_p[5]),  .M6  (m_p[6]),
    .stream     (bus_if.slave),
    .done       (done),
    .err_sym    (err_sym),
    .total_bits (total_bits)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte sink: each handshaken byte is matched against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      frame_bytes++;
      if (exp_q.size() == 0) begin
        check("sb_underflow", {23'd0, bus_if.out_last, bus_if.out_byte}, 32'h1ff);
      end else begin
        check("byte", {23'd0, bus_if.out_last, bus_if.out_byte}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic load_table(input logic zero);
    for (int i = 1; i <= 6; i++) begin
      hc_p[i] = zero ? 8'h00 : tbl_hc[i];
      m_p[i]  = zero ? 8'h00 : tbl_m[i];
    end
    code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      hc_p[i] = tbl_hc[i];
      m_p[i]  = tbl_m[i];
    end
  endtask

  task automatic build_expect();
    bit   bits_q [$];
    int   nb;
    logic [7:0] b;
    exp_total = 0;
    exp_err   = 0;
    foreach (stim_q[i]) begin
      logic [7:0] s;
      int len;
      s = stim_q[i];
      if (s >= 8'd1 && s <= 8'd6 && tbl_m[s] != 8'h00) begin
        len = $countones(tbl_m[s]);
        for (int j = len - 1; j >= 0; j--) bits_q.push_back(tbl_hc[s][j]);
        exp_total += len;
      end else begin
        exp_err = 1;
      end
    end
    nb = bits_q.size();
    exp_nbytes = (nb + 7) / 8;
    for (int k = 0; k < exp_nbytes; k++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) begin
        if (k * 8 + j < nb) b[7-j] = bits_q[k*8+j];
      end
      exp_q.push_back({(k == exp_nbytes - 1), b});
    end
  endtask

  task automatic drive_symbols(input logic inject);
    int t;
    for (int i = 0; i < stim_q.size(); i++) begin
      if (inject && i == 1) begin
        bus_if.sym_valid = 1'b0;
        load_table(1'b1);
      end
      bus_if.sym_valid = 1'b1;
      bus_if.sym_data  = stim_q[i];
      bus_if.sym_last  = (i == stim_q.size() - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus_if.sym_ready && t < 300);
      if (!bus_if.sym_ready) check("sym_ready_timeout", {31'd0, bus_if.sym_ready}, 32'd1);
      @(posedge clk); #1;
    end
    bus_if.sym_valid = 1'b0;
    bus_if.sym_last  = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic inject);
    int t;
    frame_bytes = 0;
    build_expect();
    load_table(1'b0);
    drive_symbols(inject);
    t = 0;
    while (!done && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check({name, "_done"},   {31'd0, done}, 32'd1);
    check({name, "_total"},  {16'd0, total_bits}, exp_total);
    check({name, "_err"},    {31'd0, err_sym}, exp_err);
    check({name, "_nbytes"}, frame_bytes, exp_nbytes);
    check({name, "_sb_left"}, exp_q.size(), 0);
  endtask

  task automatic stall_ctrl();
    int t;
    int saw_low;
    t = 0;
    saw_low = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus_if.out_valid && t < 300);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      check("bp_valid", {31'd0, bus_if.out_valid}, 32'd1);
      check("bp_byte", {24'd0, bus_if.out_byte}, 32'hff);
      if (!bus_if.sym_ready) saw_low++;
    end
    check("bp_sym_ready_dropped", {31'd0, (saw_low > 0)}, 32'd1);
    @(posedge clk); #1;
    bus_if.out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    code_valid = 1'b0;
    bus_if.sym_valid = 1'b0;
    bus_if.sym_data  = 8'h00;
    bus_if.sym_last  = 1'b0;
    bus_if.out_ready = 1'b1;
    tbl_hc[1] = 8'h00; tbl_m[1] = 8'h01;
    tbl_hc[2] = 8'h02; tbl_m[2] = 8'h03;
    tbl_hc[3] = 8'h06; tbl_m[3] = 8'h07;
    tbl_hc[4] = 8'h0E; tbl_m[4] = 8'h0F;
    tbl_hc[5] = 8'h1E; tbl_m[5] = 8'h1F;
    tbl_hc[6] = 8'h1F; tbl_m[6] = 8'h1F;
    for (int i = 1; i <= 6; i++) begin
      hc_p[i] = 8'h00;
      m_p[i]  = 8'h00;
    end
    #2 rst_n = 1'b0;
    #10;
    check("rst_sym_ready", {31'd0, bus_if.sym_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rst_out_last",  {31'd0, bus_if.out_last}, 32'd0);
    check("rst_out_byte",  {24'd0, bus_if.out_byte}, 32'd0);
    check("rst_done",      {31'd0, done}, 32'd0);
    check("rst_err",       {31'd0, err_sym}, 32'd0);
    check("rst_total",     {16'd0, total_bits}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    stim_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_frame("pack", 1'b0);

    stim_q = '{8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6};
    run_frame("aligned", 1'b1);

    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(8'd6);
    bus_if.out_ready = 1'b0;
    fork
      run_frame("backpressure", 1'b0);
      stall_ctrl();
    join

    stim_q = '{8'd1, 8'd0, 8'd9, 8'd2};
    run_frame("invalid", 1'b0);

    stim_q = '{8'd0};
    run_frame("empty", 1'b0);

    // Reset while the flush holds a byte that the sink refuses
    stim_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    frame_bytes = 0;
    build_expect();
    bus_if.out_ready = 1'b0;
    load_table(1'b0);
    drive_symbols(1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("arst_out_byte",  {24'd0, bus_if.out_byte}, 32'd0);
    check("arst_out_last",  {31'd0, bus_if.out_last}, 32'd0);
    check("arst_total",     {16'd0, total_bits}, 32'd0);
    check("arst_done",      {31'd0, done}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    bus_if.sym_valid = 1'b1;
    bus_if.sym_data  = 8'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("wait_tbl_sym_ready", {31'd0, bus_if.sym_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus_if.sym_valid = 1'b0;
    run_frame("restart", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
